efuse_req_sched: RTL and testbench
==================================

Name: efuse_req_sched

Overview:
- Sequencer/arbiter in front of efuse_ctrl; shares the single eFuse read/write engine between PMU autoload and software register requests.
- Autoload walks every NR-bit read segment, assembling a 256-bit shadow image for reg_ctrl/trim consumers.
- Software reads/writes are arbitrated behind autoload and acknowledged with a done/error pulse.
- Sits between pmu/reg_ctrl and efuse_ctrl in the 6.5 MHz gated domain. Drives efuse_ctrl start, mode and select; watches its busy and done.

Parameters:
NR, 64, read segment width; must be a power of two dividing 256; NSEG = 256/NR, SEL_W = clog2(NSEG), minimum 1.
BUSY_TO, 16, maximum cycles from start until efuse_busy must rise.
DONE_TO, 1048575, maximum cycles in WAIT_DONE; counter width is clog2(DONE_TO+1).
GAP_CYC, 2, idle cycles inserted between consecutive efuse_ctrl transactions; 0 is legal.

Ports:
clk  in  1  block clock, 6.5M gated
rst_n  in  1  asynchronous active-low reset
autoload_req  in  1  one-cycle pulse from PMU requesting full autoload
sw_req  in  1  level; SW transaction request, held until sw_ack
sw_write  in  1  0 = read, 1 = write; sampled at grant
sw_sel  in  SEL_W  segment select; sampled at grant
efuse_start  out  1  one-cycle start pulse to efuse_ctrl
efuse_mode  out  2  2'b00 = read, 2'b01 = write; held for the whole transaction
efuse_sel  out  SEL_W  read/write select; held for the whole transaction
efuse_busy  in  1  busy from efuse_ctrl
read_done  in  1  read completion pulse
write_done  in  1  write completion pulse
read_data  in  NR  read data; valid in the read_done cycle
shadow_data  out  256  assembled autoload image
autoload_done  out  1  one-cycle pulse at autoload end, success or abort
autoload_vld  out  1  level; shadow_data is complete and valid
autoload_err  out  1  level; last autoload aborted on timeout
sw_ack  out  1  one-cycle pulse when the SW transaction ends
sw_err  out  1  valid with sw_ack; 1 = timeout
sw_rdata  out  NR  captured data of the last successful SW read
sched_busy  out  1  state != IDLE, or autoload pending

Behaviour:
- Reset: all outputs 0; state IDLE; segment index 0; pending flag 0. Reset mid-transaction returns to IDLE immediately, with no ack or done pulse.
- States:
  - IDLE: an autoload request (or pending flag) is served first; otherwise sw_req is served. Grant latches mode/sel, sets the owner, goes to ISSUE.
  - ISSUE: one cycle; efuse_start=1; then WAIT_BUSY.
  - WAIT_BUSY: waits for efuse_busy=1, then WAIT_DONE. After BUSY_TO cycles without busy, go to ERR.
  - WAIT_DONE: waits for the done matching the mode (read_done for read, write_done for write); the other done is ignored. After DONE_TO cycles, go to ERR. On done, go to GAP.
  - GAP: counts GAP_CYC cycles (skipped if 0). Then:
    - autoload owner with index < NSEG-1: increment index, go to ISSUE;
    - otherwise go to IDLE.
  - ERR: one cycle; reports the error; go to IDLE.
- Autoload:
  - Mode forced to read; sel = segment index 0..NSEG-1.
  - Start of autoload clears autoload_vld and autoload_err.
  - On read_done: shadow_data[idx*NR +: NR] <= read_data.
  - After the last segment's GAP: autoload_done=1 for one cycle, autoload_vld=1.
  - On ERR: autoload_done=1, autoload_err=1, autoload_vld stays 0, and the shadow keeps the partial image. Index resets to 0.
  - shadow_data is held otherwise.
- SW:
  - On read done: sw_rdata <= read_data; sw_ack=1, sw_err=0 in the cycle GAP completes (or the done cycle +1 if GAP_CYC=0).
  - On ERR: sw_ack=1, sw_err=1; sw_rdata is unchanged.
  - Requester must drop sw_req the cycle after sw_ack. A sw_req still high in IDLE after ack starts a new transaction.
  - sw_req dropped before grant: no transaction.
- Simultaneous events:
  - autoload_req and sw_req both in IDLE: autoload wins; SW waits.
  - autoload_req during a SW transaction: sets the pending flag, served at the next IDLE.
  - autoload_req during an active autoload: ignored.
  - Both done inputs high in one cycle: only the one matching the mode is used.
- Latency: grant to efuse_start = 1 cycle. Autoload total = NSEG × (transaction + GAP_CYC + 1) approx.

Test Plan:
- NR=64, autoload_req pulse, model returns segment data 64'hA0..A3 patterns → 4 efuse_start pulses with sel 0,1,2,3, mode 0; shadow_data = {seg3,seg2,seg1,seg0}; one autoload_done, autoload_vld=1, autoload_err=0.
- sw_req with sw_write=1, sw_sel=2 → efuse_mode=2'b01, efuse_sel=2 held until write_done; sw_ack=1, sw_err=0 exactly 1+GAP_CYC cycles after write_done.
- autoload_req and sw_req read sel=1 in the same cycle → all 4 autoload segments complete first, then the SW read; sw_rdata = segment-1 data.
- Model never raises efuse_busy → ERR after BUSY_TO=16 cycles; autoload_done and autoload_err=1, autoload_vld=0; next autoload_req clears autoload_err and succeeds.
- SW read where busy rises but read_done never arrives (DONE_TO overridden to 100) → sw_ack with sw_err=1 at 100 cycles; sw_rdata unchanged.
- rst_n asserted in WAIT_DONE of segment 2 → all outputs 0 immediately, no autoload_done pulse; after release, a new autoload_req restarts from sel 0.

Source files
------------

// File: rtl/efuse_req_sched_if.sv
// efuse_ctrl engine port bundle: start/mode/select out, busy/done/data back.
interface efuse_req_sched_if #(
    parameter int NR    = 64,
    parameter int SEL_W = 2
);
    logic             efuse_start;
    logic [1:0]       efuse_mode;
    logic [SEL_W-1:0] efuse_sel;
    logic             efuse_busy;
    logic             read_done;
    logic             write_done;
    logic [NR-1:0]    read_data;

    // scheduler side
    modport master (
        output efuse_start, efuse_mode, efuse_sel,
        input  efuse_busy, read_done, write_done, read_data
    );

    // efuse_ctrl side
    modport slave (
        input  efuse_start, efuse_mode, efuse_sel,
        output efuse_busy, read_done, write_done, read_data
    );
endinterface

// File: rtl/efuse_req_sched.sv
// Shares the single eFuse engine between PMU autoload (full 256-bit shadow
// image, segment by segment) and software single-segment reads/writes.
module efuse_req_sched #(
    parameter int  NR      = 64,
    parameter int  BUSY_TO = 16,
    parameter int  DONE_TO = 1048575,
    parameter int  GAP_CYC = 2,
    localparam int NSEG    = 256 / NR,
    localparam int SEL_W   = (NSEG > 1) ? $clog2(NSEG) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             autoload_req,
    input  logic             sw_req,
    input  logic             sw_write,
    input  logic [SEL_W-1:0] sw_sel,
    efuse_req_sched_if.master efuse,
    output logic [255:0]     shadow_data,
    output logic             autoload_done,
    output logic             autoload_vld,
    output logic             autoload_err,
    output logic             sw_ack,
    output logic             sw_err,
    output logic [NR-1:0]    sw_rdata,
    output logic             sched_busy
);
    // One shared cycle counter, wide enough for the longest of the timeouts.
    localparam int CMAX = (DONE_TO > BUSY_TO) ?
                          ((DONE_TO > GAP_CYC) ? DONE_TO : GAP_CYC) :
                          ((BUSY_TO > GAP_CYC) ? BUSY_TO : GAP_CYC);
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP, ERR
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             owner_q;      // 1 = autoload, 0 = software
    logic             pend_q;
    logic [1:0]       mode_q;
    logic [SEL_W-1:0] sel_q;        // doubles as autoload segment index
    logic [255:0]     shadow_q;
    logic [NR-1:0]    sw_rdata_q;
    logic             al_vld_q, al_err_q;
    logic             start_c, al_done_c, ack_c, err_c;

    logic al_go, done_hit, gap_end, al_more;
    assign al_go    = autoload_req | pend_q;
    // Only the done matching the latched mode counts; the other is ignored.
    assign done_hit = mode_q[0] ? efuse.write_done : efuse.read_done;
    assign gap_end  = (cnt_q == CW'(GAP_CYC));
    assign al_more  = owner_q && (sel_q != SEL_W'(NSEG - 1));

    // State register; counter restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q != state_d) ? '0 : cnt_q + 1'b1;
        end
    end

    // Next-state: issue, busy handshake, done wait, inter-transaction gap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (al_go || sw_req) state_d = ISSUE;
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (efuse.efuse_busy)                  state_d = WAIT_DONE;
                       else if (cnt_q == CW'(BUSY_TO - 1))    state_d = ERR;
            WAIT_DONE: if (done_hit)                          state_d = GAP;
                       else if (cnt_q == CW'(DONE_TO - 1))    state_d = ERR;
            GAP:       if (gap_end) state_d = al_more ? ISSUE : IDLE;
            ERR:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs: start pulse in ISSUE, completion pulses at gap end or error.
    always_comb begin
        start_c   = 1'b0;
        al_done_c = 1'b0;
        ack_c     = 1'b0;
        err_c     = 1'b0;
        case (state_q)
            ISSUE: start_c = 1'b1;
            GAP:   if (gap_end && !al_more) begin
                       al_done_c = owner_q;
                       ack_c     = !owner_q;
                   end
            ERR:   begin
                       al_done_c = owner_q;
                       ack_c     = !owner_q;
                       err_c     = !owner_q;
                   end
            default: ;
        endcase
    end

    // Grant, pending autoload, segment stepping, data capture, status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= 1'b0;
            pend_q     <= 1'b0;
            mode_q     <= 2'b00;
            sel_q      <= '0;
            shadow_q   <= '0;
            sw_rdata_q <= '0;
            al_vld_q   <= 1'b0;
            al_err_q   <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                if (al_go) begin
                    owner_q  <= 1'b1;
                    mode_q   <= 2'b00;
                    sel_q    <= '0;
                    pend_q   <= 1'b0;
                    al_vld_q <= 1'b0;
                    al_err_q <= 1'b0;
                end else if (sw_req) begin
                    owner_q <= 1'b0;
                    mode_q  <= {1'b0, sw_write};
                    sel_q   <= sw_sel;
                end
            end else if (autoload_req && !owner_q) begin
                // autoload during a SW transaction waits; during autoload it is dropped
                pend_q <= 1'b1;
            end

            if (state_q == WAIT_DONE && done_hit && !mode_q[0]) begin
                if (owner_q) shadow_q[int'(sel_q)*NR +: NR] <= efuse.read_data;
                else         sw_rdata_q <= efuse.read_data;
            end

            if (state_q == GAP && gap_end && owner_q) begin
                if (al_more) sel_q    <= sel_q + 1'b1;
                else         al_vld_q <= 1'b1;
            end

            if (state_q == ERR && owner_q) begin
                al_err_q <= 1'b1;
                sel_q    <= '0;
            end
        end
    end

    assign efuse.efuse_start = start_c;
    assign efuse.efuse_mode  = mode_q;
    assign efuse.efuse_sel   = sel_q;
    assign shadow_data       = shadow_q;
    assign autoload_done     = al_done_c;
    assign autoload_vld      = al_vld_q;
    assign autoload_err      = al_err_q;
    assign sw_ack            = ack_c;
    assign sw_err            = err_c;
    assign sw_rdata          = sw_rdata_q;
    assign sched_busy        = (state_q != IDLE) || pend_q;
endmodule

// File: tb/tb_efuse_req_sched.sv
// Directed bench: behavioural efuse_ctrl model plus vector table for SW
// transactions and hand sequences for autoload, timeouts and reset.
module tb_efuse_req_sched;
    localparam int NR  = 64;
    localparam int GAP = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         autoload_req, sw_req, sw_write;
    logic [1:0]   sw_sel;
    logic [255:0] shadow_data;
    logic         autoload_done, autoload_vld, autoload_err;
    logic         sw_ack, sw_err, sched_busy;
    logic [NR-1:0] sw_rdata;

    efuse_req_sched_if #(.NR(NR), .SEL_W(2)) efuse();

    efuse_req_sched #(.NR(NR), .BUSY_TO(16), .DONE_TO(100), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .autoload_req(autoload_req), .sw_req(sw_req),
        .sw_write(sw_write), .sw_sel(sw_sel), .efuse(efuse),
        .shadow_data(shadow_data), .autoload_done(autoload_done),
        .autoload_vld(autoload_vld), .autoload_err(autoload_err),
        .sw_ack(sw_ack), .sw_err(sw_err), .sw_rdata(sw_rdata),
        .sched_busy(sched_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    int ack_cyc, al_cyc, start_cyc, done_cyc;
    logic [1:0] st_mode_last, done_mode;
    logic [1:0] st_sel_last, done_sel;
    bit no_busy = 0, no_done = 0, both_done = 0;
    int st_sel[$];
    int al_done_cnt = 0;

    function automatic logic [63:0] seg(input int s);
        logic [7:0] b;
        b = 8'hA0 + 8'(s);
        return {8{b}};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Start / done pulse monitor.
    always @(negedge clk) begin
        if (efuse.efuse_start) st_sel.push_back(int'(efuse.efuse_sel));
        if (autoload_done) al_done_cnt++;
    end

    // efuse_ctrl model: busy one cycle after start, done three cycles later.
    always begin
        @(negedge clk);
        if (efuse.efuse_start) begin
            st_mode_last = efuse.efuse_mode;
            st_sel_last  = efuse.efuse_sel;
            start_cyc    = cyc;
            if (!no_busy) begin
                @(negedge clk);
                efuse.efuse_busy = 1'b1;
                if (no_done) begin
                    for (int i = 0; i < 300 && !(sw_ack || autoload_done); i++) @(negedge clk);
                    efuse.efuse_busy = 1'b0;
                end else begin
                    repeat (3) @(negedge clk);
                    done_mode = efuse.efuse_mode;
                    done_sel  = efuse.efuse_sel;
                    done_cyc  = cyc;
                    efuse.efuse_busy = 1'b0;
                    efuse.read_data  = st_mode_last[0] ? 64'hBAD0_BAD0_BAD0_BAD0 : seg(int'(st_sel_last));
                    if (!st_mode_last[0] || both_done) efuse.read_done  = 1'b1;
                    if (st_mode_last[0]  || both_done) efuse.write_done = 1'b1;
                    @(negedge clk);
                    efuse.read_done  = 1'b0;
                    efuse.write_done = 1'b0;
                end
            end
        end
    end

    task automatic pulse_al();
        autoload_req = 1'b1;
        @(negedge clk);
        autoload_req = 1'b0;
    endtask

    task automatic wait_al_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (autoload_done) begin ok = 1; al_cyc = cyc; end
        end
    endtask

    task automatic sw_txn(input bit wr, input int sel, output bit err, output bit ok);
        sw_write = wr;
        sw_sel   = 2'(sel);
        sw_req   = 1'b1;
        ok = 0; err = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (sw_ack) begin ok = 1; err = sw_err; ack_cyc = cyc; end
        end
        sw_req = 1'b0;
    endtask

    task automatic check_starts(input string name, input int exp[$]);
        check({name, "_cnt"}, 256'(st_sel.size()), 256'(exp.size()));
        for (int i = 0; i < exp.size() && i < st_sel.size(); i++)
            check(name, 256'(st_sel[i]), 256'(exp[i]));
    endtask

    typedef struct {
        bit          wr;
        int          sel;
        bit          both;
        logic [1:0]  exp_mode;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vt[4];
    logic [255:0] full_img;

    initial begin
        bit ok, err;
        int ad0;

        vt[0] = '{wr: 1, sel: 2, both: 0, exp_mode: 2'b01, exp_rdata: 64'h0};
        vt[1] = '{wr: 0, sel: 1, both: 0, exp_mode: 2'b00, exp_rdata: seg(1)};
        vt[2] = '{wr: 0, sel: 3, both: 1, exp_mode: 2'b00, exp_rdata: seg(3)};
        vt[3] = '{wr: 1, sel: 0, both: 1, exp_mode: 2'b01, exp_rdata: seg(3)};
        full_img = {seg(3), seg(2), seg(1), seg(0)};

        rst_n = 1'b0; autoload_req = 0; sw_req = 0; sw_write = 0; sw_sel = 0;
        efuse.efuse_busy = 0; efuse.read_done = 0; efuse.write_done = 0; efuse.read_data = '0;
        repeat (3) @(negedge clk);
        check("rst_start",   256'(efuse.efuse_start), 0);
        check("rst_mode",    256'(efuse.efuse_mode), 0);
        check("rst_sel",     256'(efuse.efuse_sel), 0);
        check("rst_shadow",  shadow_data, 0);
        check("rst_vld_err", 256'({autoload_vld, autoload_err, autoload_done}), 0);
        check("rst_sw",      256'({sw_ack, sw_err, sched_busy}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Autoload: four reads, sel 0..3, shadow assembled.
        st_sel.delete();
        pulse_al();
        wait_al_done(ok);
        check("al1_done_seen", 256'(ok), 1);
        repeat (3) @(negedge clk);
        check_starts("al1_sel", '{0, 1, 2, 3});
        check("al1_mode",    256'(st_mode_last), 0);
        check("al1_shadow",  shadow_data, full_img);
        check("al1_vld",     256'(autoload_vld), 1);
        check("al1_err",     256'(autoload_err), 0);
        check("al1_done_n",  256'(al_done_cnt), 1);

        // SW vector table.
        for (int v = 0; v < 4; v++) begin
            both_done = vt[v].both;
            sw_txn(vt[v].wr, vt[v].sel, err, ok);
            check($sformatf("v%0d_ack_seen", v), 256'(ok), 1);
            check($sformatf("v%0d_st_mode", v), 256'(st_mode_last), 256'(vt[v].exp_mode));
            check($sformatf("v%0d_st_sel", v), 256'(st_sel_last), 256'(vt[v].sel));
            check($sformatf("v%0d_dn_mode", v), 256'(done_mode), 256'(vt[v].exp_mode));
            check($sformatf("v%0d_dn_sel", v), 256'(done_sel), 256'(vt[v].sel));
            check($sformatf("v%0d_ack_lat", v), 256'(ack_cyc - done_cyc), 256'(1 + GAP));
            check($sformatf("v%0d_err", v), 256'(err), 0);
            @(negedge clk);
            check($sformatf("v%0d_rdata", v), 256'(sw_rdata), 256'(vt[v].exp_rdata));
        end
        both_done = 0;

        // Simultaneous autoload + SW read sel 1: autoload first.
        st_sel.delete();
        sw_write = 0; sw_sel = 2'd1; sw_req = 1'b1;
        pulse_al();
        sw_txn(0, 1, err, ok);
        check("sim_ack_seen", 256'(ok), 1);
        #1;
        check_starts("sim_sel", '{0, 1, 2, 3, 1});
        @(negedge clk);
        check("sim_rdata", 256'(sw_rdata), 256'(seg(1)));
        check("sim_vld", 256'(autoload_vld), 1);

        // Autoload arriving mid SW transaction is held pending.
        st_sel.delete();
        fork
            sw_txn(0, 3, err, ok);
            begin repeat (3) @(negedge clk); pulse_al(); end
        join
        check("pend_ack_seen", 256'(ok), 1);
        check("pend_busy", 256'(sched_busy), 1);
        wait_al_done(ok);
        check("pend_done_seen", 256'(ok), 1);
        #1;
        check_starts("pend_sel", '{3, 0, 1, 2, 3});

        // Busy never rises: ERR after 16 cycles.
        repeat (4) @(negedge clk);
        st_sel.delete();
        no_busy = 1;
        pulse_al();
        wait_al_done(ok);
        check("bto_done_seen", 256'(ok), 1);
        check("bto_lat", 256'(al_cyc - start_cyc), 17);
        @(negedge clk);
        check("bto_err", 256'(autoload_err), 1);
        check("bto_vld", 256'(autoload_vld), 0);
        check("bto_starts", 256'(st_sel.size()), 1);
        check("bto_shadow", shadow_data, full_img);
        no_busy = 0;
        repeat (2) @(negedge clk);
        pulse_al();
        check("retry_err_clr", 256'(autoload_err), 0);
        wait_al_done(ok);
        check("retry_done_seen", 256'(ok), 1);
        @(negedge clk);
        check("retry_vld", 256'(autoload_vld), 1);
        check("retry_err", 256'(autoload_err), 0);

        // Done never arrives on a SW read: timeout error after 100 cycles.
        no_done = 1;
        sw_txn(0, 2, err, ok);
        check("dto_ack_seen", 256'(ok), 1);
        check("dto_err", 256'(err), 1);
        check("dto_lat", 256'(ack_cyc - start_cyc), 102);
        @(negedge clk);
        check("dto_rdata", 256'(sw_rdata), 256'(seg(3)));
        no_done = 0;
        repeat (4) @(negedge clk);

        // Reset in WAIT_DONE of segment 2.
        pulse_al();
        ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (efuse.efuse_start && efuse.efuse_sel == 2'd2) ok = 1;
        end
        check("rst2_seen_sel2", 256'(ok), 1);
        repeat (2) @(negedge clk);
        ad0 = al_done_cnt;
        rst_n = 1'b0;
        #1;
        check("rst2_shadow", shadow_data, 0);
        check("rst2_ctl", 256'({efuse.efuse_start, efuse.efuse_mode, efuse.efuse_sel}), 0);
        check("rst2_stat", 256'({autoload_done, autoload_vld, autoload_err, sw_ack, sw_err, sched_busy}), 0);
        check("rst2_rdata", 256'(sw_rdata), 0);
        repeat (3) @(negedge clk);
        check("rst2_no_done", 256'(al_done_cnt), 256'(ad0));
        st_sel.delete();
        rst_n = 1'b1;
        pulse_al();
        wait_al_done(ok);
        check("rst2_re_done", 256'(ok), 1);
        @(negedge clk);
        check_starts("rst2_sel", '{0, 1, 2, 3});
        check("rst2_re_shadow", shadow_data, full_img);
        check("rst2_re_vld", 256'(autoload_vld), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
